// File: rtl/operand_stage_if.sv
// operand_stage_if -- bundle of every non-clock signal of operand_stage.
//   command side : cmdValid/cmdReady handshake, register addresses,
//                  opcode fields, immediate, write/flag enables
//   ALU side     : operand1/2, carryIn, operationType/operation out;
//                  result, carryOut/zeroOut/negativeOut back (combinational ALU)
//   status       : flagC/Z/N, done pulse
//   debug        : dbgAddr -> dbgData combinational register read
// slave  = the operand stage itself; master = command source + ALU + debug reader.
interface operand_stage_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3
);
  logic                      cmdValid;
  logic                      cmdReady;
  logic [REG_ADDR_WIDTH-1:0] cmdDst;
  logic [REG_ADDR_WIDTH-1:0] cmdSrc1;
  logic [REG_ADDR_WIDTH-1:0] cmdSrc2;
  logic [2:0]                cmdOperationType;
  logic [2:0]                cmdOperation;
  logic                      cmdUseImm;
  logic [DATA_WIDTH-1:0]     cmdImmediate;
  logic                      cmdWriteEnable;
  logic                      cmdFlagEnable;

  logic [DATA_WIDTH-1:0]     operand1;
  logic [DATA_WIDTH-1:0]     operand2;
  logic                      carryIn;
  logic [2:0]                operationType;
  logic [2:0]                operation;
  logic [DATA_WIDTH-1:0]     result;
  logic                      carryOut;
  logic                      zeroOut;
  logic                      negativeOut;

  logic                      flagC;
  logic                      flagZ;
  logic                      flagN;
  logic                      done;

  logic [REG_ADDR_WIDTH-1:0] dbgAddr;
  logic [DATA_WIDTH-1:0]     dbgData;

  modport slave (
    input  cmdValid, cmdDst, cmdSrc1, cmdSrc2, cmdOperationType, cmdOperation,
           cmdUseImm, cmdImmediate, cmdWriteEnable, cmdFlagEnable,
           result, carryOut, zeroOut, negativeOut, dbgAddr,
    output cmdReady, operand1, operand2, carryIn, operationType, operation,
           flagC, flagZ, flagN, done, dbgData
  );

  modport master (
    output cmdValid, cmdDst, cmdSrc1, cmdSrc2, cmdOperationType, cmdOperation,
           cmdUseImm, cmdImmediate, cmdWriteEnable, cmdFlagEnable,
           result, carryOut, zeroOut, negativeOut, dbgAddr,
    input  cmdReady, operand1, operand2, carryIn, operationType, operation,
           flagC, flagZ, flagN, done, dbgData
  );
endinterface

// File: rtl/operand_stage.sv
// operand_stage -- register file + operand fetch / writeback sequencer for
// an external combinational ALU.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : operand_stage_if.slave (command, ALU, flags, done, debug read)
//
// state | meaning
// IDLE  | cmdReady=1, waiting for a command
// EXEC  | operands presented to the ALU, result settles
// WRITE | sampled result/flags held, done=1, commit on leaving
module operand_stage #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3
) (
  input  logic            clk,
  input  logic            reset,
  operand_stage_if.slave  bus
);
  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_e;

  state_e                    state_q, state_d;
  logic                      accept;

  logic [DATA_WIDTH-1:0]     regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]     op1_q, op2_q;
  logic                      cin_q;
  logic [2:0]                optype_q, op_q;
  logic [REG_ADDR_WIDTH-1:0] dst_q;
  logic                      we_q, fe_q;
  logic [DATA_WIDTH-1:0]     res_q;
  logic                      res_c_q, res_z_q, res_n_q;
  logic                      flag_c_q, flag_z_q, flag_n_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    bus.cmdReady = 1'b0;
    bus.done     = 1'b0;
    case (state_q)
      IDLE: begin
        bus.cmdReady = 1'b1;
        if (bus.cmdValid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC:    state_d = WRITE;
      WRITE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands and the writeback controls are captured together at accept so
  // the source may move on to its next command immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op1_q    <= '0;
      op2_q    <= '0;
      cin_q    <= 1'b0;
      optype_q <= '0;
      op_q     <= '0;
      dst_q    <= '0;
      we_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else if (accept) begin
      op1_q    <= bus.cmdUseImm ? bus.cmdImmediate : regs_q[bus.cmdSrc1];
      op2_q    <= regs_q[bus.cmdSrc2];
      cin_q    <= flag_c_q;
      optype_q <= bus.cmdOperationType;
      op_q     <= bus.cmdOperation;
      dst_q    <= bus.cmdDst;
      we_q     <= bus.cmdWriteEnable;
      fe_q     <= bus.cmdFlagEnable;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q   <= '0;
      res_c_q <= 1'b0;
      res_z_q <= 1'b0;
      res_n_q <= 1'b0;
    end else if (state_q == EXEC) begin
      res_q   <= bus.result;
      res_c_q <= bus.carryOut;
      res_z_q <= bus.zeroOut;
      res_n_q <= bus.negativeOut;
    end
  end

  // Commit happens on leaving WRITE; a reset in EXEC/WRITE therefore never
  // reaches this point and the command leaves no trace.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (state_q == WRITE) begin
      if (we_q) regs_q[dst_q] <= res_q;
      if (fe_q) begin
        flag_c_q <= res_c_q;
        flag_z_q <= res_z_q;
        flag_n_q <= res_n_q;
      end
    end
  end

  assign bus.operand1      = op1_q;
  assign bus.operand2      = op2_q;
  assign bus.carryIn       = cin_q;
  assign bus.operationType = optype_q;
  assign bus.operation     = op_q;
  assign bus.flagC         = flag_c_q;
  assign bus.flagZ         = flag_z_q;
  assign bus.flagN         = flag_n_q;
  assign bus.dbgData       = regs_q[bus.dbgAddr];
endmodule
